pipeline_stall_ctrl: RTL and testbench

//  Central hazard/stall sequencer for the 5-stage MIPS pipeline. Merges per-stage stall requests into the 6-bit

---
 rtl/pipeline_stall_ctrl_pkg.sv | 38 +++
 rtl/pipeline_stall_ctrl_counter.sv | 32 +++
 rtl/pipeline_stall_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared stall-vector layout, per-stage stall masks and sequencer state encoding
// for pipeline_stall_ctrl and its counter.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  typedef logic [STALL_WB:STALL_PC] stall_vec_t;

  // A stalled stage freezes itself and every stage upstream of it.
  function automatic stall_vec_t mask_upto(input int unsigned top);
    stall_vec_t m;
    for (int unsigned i = STALL_PC; i <= STALL_WB; i++) begin
      m[i] = (i <= top) ? STALL_ENABLE : STALL_DISABLE;
    end
    return m;
  endfunction

  localparam stall_vec_t STALL_NONE     = '0;
  localparam stall_vec_t STALL_MASK_IF  = mask_upto(STALL_IF);
  localparam stall_vec_t STALL_MASK_ID  = mask_upto(STALL_ID);
  localparam stall_vec_t STALL_MASK_EX  = mask_upto(STALL_EX);
  localparam stall_vec_t STALL_MASK_MEM = mask_upto(STALL_MEM);

  typedef enum logic [1:0] {
    StIdle,
    StMulti,
    StFlush
  } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_counter.sv
// multi_cycle_counter: loadable down-counter with freeze and zero flag; never wraps below zero.
module multi_cycle_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: stall vector, MULT/DIV sequencing, exception flush.
// Optional STALL_CTRL_PERF_EN adds saturating stall-cycle and flush counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        mem_stall_req,
  input  logic        ex_multi_start,
  input  logic        ex_multi_is_div,
  output logic        ex_multi_done,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flush_count
`endif
);

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q;
  logic [31:0]      flush_pc_q;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             start_ok;
  logic             dec;
  logic             ex_busy;
  stall_vec_t       stall_vec;

  assign load_val = ex_multi_is_div ? DivLoad : MulLoad;
  // A start under a MEM stall is dropped; EX keeps presenting it.
  assign start_ok = (state_q == StIdle) && ex_multi_start && !mem_stall_req && !exc_req;
  assign dec      = (state_q == StMulti) && !mem_stall_req && !exc_req;
  assign ex_busy  = ((state_q == StMulti) && !cnt_zero) || (start_ok && (load_val != '0));

  multi_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (exc_req),
    .load     (start_ok),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    stall_vec = STALL_NONE;
    if (!exc_req && (state_q != StFlush)) begin
      if (mem_stall_req)     stall_vec = STALL_MASK_MEM;
      else if (ex_busy)      stall_vec = STALL_MASK_EX;
      else if (id_stall_req) stall_vec = STALL_MASK_ID;
      else if (if_stall_req) stall_vec = STALL_MASK_IF;
    end
  end

  assign stall         = stall_vec;
  assign flush         = (state_q == StFlush);
  assign flush_pc      = flush_pc_q;
  assign ex_multi_done = (state_q == StMulti) && cnt_zero && !mem_stall_req && !exc_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      flush_pc_q <= '0;
    end else if (exc_req) begin
      state_q    <= StFlush;
      flush_pc_q <= exc_target;
    end else begin
      unique case (state_q)
        StIdle:  if (start_ok) state_q <= StMulti;
        StMulti: if (ex_multi_done) state_q <= StIdle;
        StFlush: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if ((stall_vec != STALL_NONE) && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
      if (flush && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 1'b1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model. Honours STALL_CTRL_PERF_EN when defined.
module tb_pipeline_stall_ctrl;

  localparam int MUL = 4;
  localparam int DIV = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_stall_req, id_stall_req, mem_stall_req;
  logic        ex_multi_start, ex_multi_is_div, ex_multi_done;
  logic        exc_req;
  logic [31:0] exc_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  pipeline_stall_ctrl #(
    .MUL_CYCLES (MUL),
    .DIV_CYCLES (DIV),
    .CNT_W      (6)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .if_stall_req    (if_stall_req),
    .id_stall_req    (id_stall_req),
    .mem_stall_req   (mem_stall_req),
    .ex_multi_start  (ex_multi_start),
    .ex_multi_is_div (ex_multi_is_div),
    .ex_multi_done   (ex_multi_done),
    .exc_req         (exc_req),
    .exc_target      (exc_target),
    .stall           (stall),
    .flush           (flush),
    .flush_pc        (flush_pc)
`ifdef STALL_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    int          ps;
    int          pf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: m_left = EX stall cycles still owed by the current op (-1 = no op in EX).
  bit          m_flush;
  int          m_left;
  logic [31:0] m_pc;
  int          m_ps, m_pf;

  task automatic model_reset();
    m_flush = 0;
    m_left  = -1;
    m_pc    = '0;
    m_ps    = 0;
    m_pf    = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input bit ifr, input bit idr, input bit memr, input bit st,
                       input bit isdiv, input bit exc, input logic [31:0] tgt);
    exp_t e;
    int   top;
    int   lat;
    bit   ex_stall;
    @(posedge clock);
    #1;
    if_stall_req    = ifr;
    id_stall_req    = idr;
    mem_stall_req   = memr;
    ex_multi_start  = st;
    ex_multi_is_div = isdiv;
    exc_req         = exc;
    exc_target      = tgt;

    e.stall = '0;
    e.done  = 1'b0;
    e.flush = m_flush;
    e.pc    = m_pc;
    if (exc) begin
      m_flush = 1;
      m_pc    = tgt;
      m_left  = -1;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      lat      = isdiv ? DIV : MUL;
      ex_stall = (m_left > 0) || (m_left < 0 && st && !memr && lat > 1);
      top      = memr ? 4 : ex_stall ? 3 : idr ? 2 : ifr ? 1 : 0;
      e.stall  = (top == 0) ? 6'd0 : 6'((1 << (top + 1)) - 1);
      e.done   = (m_left == 0) && !memr;
      if (!memr) begin
        if (m_left < 0 && st) m_left = lat - 1;
        else if (m_left > 0)  m_left--;
        else if (m_left == 0) m_left = -1;
      end
    end
    e.ps = m_ps;
    e.pf = m_pf;
    if (e.stall != 0) m_ps++;
    if (e.flush) m_pf++;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    bit   bad;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      bad = (stall !== e.stall) || (flush !== e.flush) || (flush_pc !== e.pc) ||
            (ex_multi_done !== e.done);
`ifdef STALL_CTRL_PERF_EN
      bad = bad || (perf_stall_cycles !== 32'(e.ps)) || (perf_flush_count !== 16'(e.pf));
`endif
      if (bad) begin
        n_bad++;
        $display("FAIL cycle@%0t: got stall=%b flush=%b pc=%h done=%b expected stall=%b flush=%b pc=%h done=%b",
                 $time, stall, flush, flush_pc, ex_multi_done, e.stall, e.flush, e.pc, e.done);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #1;
    {if_stall_req, id_stall_req, mem_stall_req, ex_multi_start, ex_multi_is_div, exc_req} = '0;
    exc_target = '0;
    reset = 1'b0;
    #1;
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_flush", 32'(flush), 32'h0);
    check("reset_done", 32'(ex_multi_done), 32'h0);
    check("reset_flush_pc", flush_pc, 32'h0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    {if_stall_req, id_stall_req, mem_stall_req, ex_multi_start, ex_multi_is_div, exc_req} = '0;
    exc_target = '0;
    model_reset();
    do_reset();

    // Single requests, then id+mem, then a multiply start cycle.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0);
    idle(6);

    // Full divide.
    drive(0, 0, 0, 1, 1, 0, 0);
    idle(36);

    // Multiply stretched by a 3-cycle MEM wait.
    drive(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0);
    idle(6);

    // Exception aborts a divide.
    drive(0, 0, 0, 1, 1, 0, 0);
    idle(3);
    drive(0, 0, 0, 0, 0, 1, 32'hBFC00380);
    idle(40);

    // Back-to-back exceptions.
    drive(0, 0, 0, 0, 0, 1, 32'h8000_0180);
    drive(1, 1, 1, 1, 0, 1, 32'h8000_0200);
    idle(3);

    // Reset mid-divide (counter at 10), then the sequencer must be idle.
    drive(0, 0, 0, 1, 1, 0, 0);
    idle(21);
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0);

    // Perf scenario: 5 stalled cycles and one flush from a clean reset.
    do_reset();
    repeat (5) drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    idle(2);
`ifdef STALL_CTRL_PERF_EN
    @(negedge clock);
    #1;
    check("perf_stall_cycles", perf_stall_cycles, 32'd5);
    check("perf_flush_count", 32'(perf_flush_count), 32'd1);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0,
            $urandom_range(2) == 0, $urandom_range(1) == 1, $urandom_range(31) == 0, $urandom);
    end
    idle(2);

    repeat (2) @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
